vend_ctrl: RTL and testbench

VEND_CTRL -- requirements
Module: vend_ctrl

---
 rtl/vend_ctrl.sv | 129 ++++++++++++
 tb/tb_vend_ctrl.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/vend_ctrl.sv
// Vending machine controller: accumulates coins, releases one item when the
// credit reaches PRICE, and pays any remainder back one 25c unit per cycle.
//
// state  | meaning
// IDLE   | no credit held, coins accepted
// ACCUM  | 0 < credit < PRICE, coins accepted, cancel returns credit
// VEND   | dispense held for DISP_CYCLES cycles, coins rejected
// CHANGE | one change_pulse per cycle until credit is paid out
module vend_ctrl #(
  parameter int PRICE       = 4,
  parameter int MAX_CREDIT  = 12,
  parameter int CW          = 4,
  parameter int DISP_CYCLES = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          coin_valid,
  input  logic [1:0]    coin,
  input  logic          cancel,
  output logic [CW-1:0] credit,
  output logic          dispense,
  output logic          change_pulse,
  output logic          coin_reject,
  output logic          busy
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCUM  = 2'd1;
  localparam logic [1:0] VEND   = 2'd2;
  localparam logic [1:0] CHANGE = 2'd3;

  localparam int DW = (DISP_CYCLES > 1) ? $clog2(DISP_CYCLES) : 1;
  localparam logic [DW-1:0] DISP_INIT = DW'(DISP_CYCLES - 1);
  localparam logic [CW:0]   PRICE_W   = (CW+1)'(PRICE);
  localparam logic [CW:0]   MAX_W     = (CW+1)'(MAX_CREDIT);

  logic [1:0]    state;
  logic [DW-1:0] disp_cnt;
  logic [CW:0]   coin_val;
  logic [CW:0]   sum;
  logic          coin_ok;
  logic          do_cancel;

  // Decode the coin value and judge acceptance; sum is one bit wider than
  // credit so the overflow compare against MAX_CREDIT cannot wrap.
  always_comb begin
    coin_val = '0;
    case (coin)
      2'b00:   coin_val = (CW+1)'(1);
      2'b01:   coin_val = (CW+1)'(2);
      2'b10:   coin_val = (CW+1)'(4);
      default: coin_val = '0;
    endcase
    sum       = {1'b0, credit} + coin_val;
    do_cancel = cancel && (state == ACCUM);
    coin_ok   = coin_valid && !cancel && (coin != 2'b11) && (sum <= MAX_W) &&
                ((state == IDLE) || (state == ACCUM));
  end

  // Registered FSM and outputs; every response lands on the sampling edge.
  // Entering CHANGE already pays the first unit, so credit and change_pulse
  // move together and the pulse count equals the credit returned.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      credit       <= '0;
      dispense     <= 1'b0;
      change_pulse <= 1'b0;
      coin_reject  <= 1'b0;
      busy         <= 1'b0;
      disp_cnt     <= '0;
    end else begin
      coin_reject <= coin_valid && !coin_ok;
      case (state)
        IDLE, ACCUM: begin
          if (do_cancel) begin
            state        <= CHANGE;
            credit       <= credit - 1'b1;
            change_pulse <= 1'b1;
            busy         <= 1'b1;
          end else if (coin_ok) begin
            if (sum >= PRICE_W) begin
              state    <= VEND;
              credit   <= CW'(sum - PRICE_W);
              dispense <= 1'b1;
              disp_cnt <= DISP_INIT;
              busy     <= 1'b1;
            end else begin
              state  <= ACCUM;
              credit <= CW'(sum);
            end
          end
        end
        VEND: begin
          if (disp_cnt == '0) begin
            dispense <= 1'b0;
            if (credit != '0) begin
              state        <= CHANGE;
              credit       <= credit - 1'b1;
              change_pulse <= 1'b1;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end else begin
            disp_cnt <= disp_cnt - 1'b1;
          end
        end
        CHANGE: begin
          if (credit == '0) begin
            state        <= IDLE;
            change_pulse <= 1'b0;
            busy         <= 1'b0;
          end else begin
            credit <= credit - 1'b1;
          end
        end
        default: begin
          state        <= IDLE;
          credit       <= '0;
          dispense     <= 1'b0;
          change_pulse <= 1'b0;
          busy         <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vend_ctrl.sv
// Directed bench for vend_ctrl: default instance plus a PRICE=12 instance
// for the overflow-reject case. Expected values are hand-computed.
module tb_vend_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       coin_valid, cancel;
  logic [1:0] coin;
  logic [3:0] credit;
  logic       dispense, change_pulse, coin_reject, busy;

  logic       coin_valid2, cancel2;
  logic [1:0] coin2;
  logic [3:0] credit2;
  logic       dispense2, change_pulse2, coin_reject2, busy2;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  vend_ctrl dut (
    .clk(clk), .rst(rst), .coin_valid(coin_valid), .coin(coin), .cancel(cancel),
    .credit(credit), .dispense(dispense), .change_pulse(change_pulse),
    .coin_reject(coin_reject), .busy(busy)
  );

  vend_ctrl #(.PRICE(12), .MAX_CREDIT(12), .CW(4), .DISP_CYCLES(2)) dut2 (
    .clk(clk), .rst(rst), .coin_valid(coin_valid2), .coin(coin2), .cancel(cancel2),
    .credit(credit2), .dispense(dispense2), .change_pulse(change_pulse2),
    .coin_reject(coin_reject2), .busy(busy2)
  );

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_outs(input string tag, input int cr, input int d, input int p,
                            input int r, input int b);
    check({tag, ".credit"}, int'(credit), cr);
    check({tag, ".dispense"}, int'(dispense), d);
    check({tag, ".change"}, int'(change_pulse), p);
    check({tag, ".reject"}, int'(coin_reject), r);
    check({tag, ".busy"}, int'(busy), b);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic [1:0] c);
    coin_valid = 1'b1;
    coin       = c;
  endtask

  task automatic idle_in();
    coin_valid = 1'b0;
    cancel     = 1'b0;
    coin       = 2'b00;
  endtask

  initial begin
    rst = 1'b1;
    idle_in();
    coin_valid2 = 1'b0; cancel2 = 1'b0; coin2 = 2'b00;
    tick(); tick();
    rst = 1'b0;
    check_outs("reset", 0, 0, 0, 0, 0);

    // four 25c coins
    put(2'b00); tick(); check_outs("q1", 1, 0, 0, 0, 0);
    tick();             check_outs("q2", 2, 0, 0, 0, 0);
    tick();             check_outs("q3", 3, 0, 0, 0, 0);
    tick();             check_outs("q4_vend", 0, 1, 0, 0, 1);
    idle_in(); tick();  check_outs("q4_vend2", 0, 1, 0, 0, 1);
    tick();             check_outs("q4_idle", 0, 0, 0, 0, 0);

    // 50c then 1 birr: two units of change
    put(2'b01); tick(); check_outs("h1", 2, 0, 0, 0, 0);
    put(2'b10); tick(); check_outs("h_vend", 2, 1, 0, 0, 1);
    idle_in(); tick();  check_outs("h_vend2", 2, 1, 0, 0, 1);
    tick();             check_outs("h_chg1", 1, 0, 1, 0, 1);
    tick();             check_outs("h_chg2", 0, 0, 1, 0, 1);
    tick();             check_outs("h_idle", 0, 0, 0, 0, 0);

    // 25c then cancel with a coin presented
    put(2'b00); tick(); check_outs("c1", 1, 0, 0, 0, 0);
    put(2'b00); cancel = 1'b1; tick(); check_outs("c_cancel", 0, 0, 1, 1, 1);
    idle_in(); tick();  check_outs("c_idle", 0, 0, 0, 0, 0);

    // cancel in IDLE is ignored
    cancel = 1'b1; tick(); check_outs("c_ign", 0, 0, 0, 0, 0);
    idle_in();

    // invalid code in ACCUM, coin during VEND
    put(2'b00); tick(); check_outs("r1", 1, 0, 0, 0, 0);
    put(2'b11); tick(); check_outs("r_bad", 1, 0, 0, 1, 0);
    put(2'b10); tick(); check_outs("r_vend", 1, 1, 0, 0, 1);
    put(2'b00); tick(); check_outs("r_busy", 1, 1, 0, 1, 1);
    idle_in(); tick();  check_outs("r_chg", 0, 0, 1, 0, 1);
    tick();             check_outs("r_idle", 0, 0, 0, 0, 0);

    // reset during the 2nd of three change pulses, coin right after release
    put(2'b00); tick(); check_outs("x1", 1, 0, 0, 0, 0);
    put(2'b01); tick(); check_outs("x2", 3, 0, 0, 0, 0);
    put(2'b10); tick(); check_outs("x_vend", 3, 1, 0, 0, 1);
    idle_in(); tick();  check_outs("x_vend2", 3, 1, 0, 0, 1);
    tick();             check_outs("x_chg1", 2, 0, 1, 0, 1);
    tick();             check_outs("x_chg2", 1, 0, 1, 0, 1);
    rst = 1'b1; tick(); check_outs("x_rst", 0, 0, 0, 0, 0);
    rst = 1'b0; put(2'b00); tick(); check_outs("x_first", 1, 0, 0, 0, 0);
    idle_in(); tick();  check_outs("x_hold", 1, 0, 0, 0, 0);
    cancel = 1'b1; tick(); check_outs("x_cancel", 0, 0, 1, 0, 1);
    idle_in(); tick();  check_outs("x_idle", 0, 0, 0, 0, 0);

    // PRICE=12 instance: overflow reject at credit 10
    coin_valid2 = 1'b1; coin2 = 2'b10; tick();
    check("p_c4", int'(credit2), 4);
    tick();
    check("p_c8", int'(credit2), 8);
    coin2 = 2'b01; tick();
    check("p_c10", int'(credit2), 10);
    coin2 = 2'b10; tick();
    check("p_ovf.credit", int'(credit2), 10);
    check("p_ovf.reject", int'(coin_reject2), 1);
    check("p_ovf.dispense", int'(dispense2), 0);
    coin2 = 2'b01; tick();
    check("p_vend.credit", int'(credit2), 0);
    check("p_vend.dispense", int'(dispense2), 1);
    check("p_vend.reject", int'(coin_reject2), 0);
    coin_valid2 = 1'b0; tick(); tick();
    check("p_idle.dispense", int'(dispense2), 0);
    check("p_idle.busy", int'(busy2), 0);
    check("p_idle.change", int'(change_pulse2), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
